alu_datapath: RTL
=================

# alu_datapath

Register-and-arithmetic datapath for the 8-bit ALU. It executes the 18-bit control word `c[17:0]` issued each clock by the ALU control unit, and returns the status bits the control unit sequences on: `Q1`, `Q0`, `R`, `A7`, `count7`. It supports AND, OR, XOR, add, subtract, shift-add multiply steps and non-restoring divide steps, and delivers a 16-bit registered result.

## Interface
- No parameters; data width is fixed at 8 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; all state is cleared immediately while low.
- `c` in 18: control word from the control unit; one-hot or multi-hot per cycle.
- `op` in 3: opcode, stable for the whole operation.
  - 000 AND, 001 OR, 010 XOR, 011 add, 100 sub, 101 mul, 110 div.
- `inbus` in 8: operand input.
- `outbus` out 16: registered result, high byte = A, low byte = Q.
- `Q1` out 1: `Q[1]`.
- `Q0` out 1: `Q[0]`.
- `R` out 1: Booth extension bit.
- `A7` out 1: `A[7]`.
- `count7` out 1: high when `cnt == 7`.
- `dz` out 1: divide-by-zero flag (see Configuration).

## Operation
- State: A[7:0], Q[7:0], M[7:0], R, cnt[2:0], outbus[15:0], dz. Status outputs are combinational from state.
- Control bits (all take effect at the rising edge):
  - c0: Q←inbus, A←0, R←0, cnt←0.
  - c1: M←inbus.
  - c2: A←Q+M. If c15 is also set: A←Q+~M+1 (subtract). Carry-out is discarded, mod 256.
  - c16: A←Q AND/OR/XOR M, selected by op[1:0] = 00/01/10.
  - c10: A←0.
  - c11: dz←(M==0).
  - c3: A←A+M, or A←A−M when c4 is also set.
  - c5: arithmetic right shift of {A,Q,R}. A[7] is kept, A[0]→Q[7], Q[0]→R.
  - c12: logical left shift of {A,Q}. Q[7]→A[0], Q[0]←0.
  - c13: A←A+M.
  - c14: A←A−M.
  - c17: Q[0]←~A[7].
  - c6: cnt←cnt+1, wrapping 7→0.
  - c7: applies only when op=110. Q[0]←~A[7]; if A[7]=1 then A←A+M (remainder restore). No effect for other ops.
  - c8: outbus[15:8]←A.
  - c9: outbus[7:0]←Q.
- Same-cycle writes to A, priority highest first: c0, c10, c16, c2, c3, c13, c14, c7, then shifts c5 and c12.
  - The control unit never pairs an A write with a shift; if it does, the higher-priority write wins and the shift is dropped for A only.
- Same-cycle writes to Q[0]: c0 > c7 > c17 > shifts.
- An all-zero control word holds all state.
- c4 without c3 has no effect. c15 without c2 has no effect.

## Timing
- Single-cycle execution of every control bit; results are visible the cycle after the edge.
- Status outputs have zero latency from register state, so the control unit samples the values as of the current phase.
- `outbus` updates one edge after c8/c9 and then holds until the next c8/c9 or reset.
- Reset values: A=Q=M=0, R=0, cnt=0, outbus=0x0000, dz=0. Therefore Q1=Q0=R=A7=0 and count7=0.
- Reset is asynchronous and may be asserted mid-operation; state clears immediately and the next operation must start with c0.

## Configuration
- `ALU_DP_DZ_EN` defined: the dz register exists, c11 samples M==0, dz holds until the next c0 or reset.
- `ALU_DP_DZ_EN` undefined: dz is tied to 0 and c11 is ignored; no extra register is built.

## Test plan
- AND: op=000. c0 with inbus=0xCA, c1 with inbus=0x0F, then c2, c16, then c8|c9. Expect outbus=0x0ACA.
- Sub: op=100. X=0x05 via c0, Y=0x07 via c1, then c2|c15, then c8|c9. Expect A7=1 and outbus=0xFE05. Add 0xFF+0x02 with op=011 gives A=0x01.
- Mul step: op=101. X=0x03, M=0x05, R=0, so Q1Q0R=110. Apply c3|c4, expect A=0xFB. Then c5, expect A=0xFD, Q=0x81, R=1, Q0=1.
- Div step: op=110. X=0x80, M=0x03, c10. Apply c12, expect A=0x01, Q=0x00. Apply c14, expect A=0xFE, A7=1. Apply c17, expect Q[0]=0. Apply c7, expect A=0x01, Q[0]=0.
- Counter: after c0, seven c6 pulses give count7=1; the eighth gives cnt=0, count7=0.
- Reset and dz: mid-multiply, drive reset low between edges; all outputs are 0 immediately. With `ALU_DP_DZ_EN`, M=0x00 then c11 gives dz=1, and the next c0 gives dz=0.

Source files
------------

// File: rtl/alu_datapath.sv
// Register-and-arithmetic datapath for the 8-bit ALU; executes one 18-bit control word per clock (optional dz flag under ALU_DP_DZ_EN).
// Latency: every control bit takes effect at the next rising edge; status outputs are combinational from state.
// Backpressure: none; the control unit owns sequencing and a zero control word holds all state.
module alu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] c,
  input  logic [2:0]  op,
  input  logic [7:0]  inbus,
  output logic [15:0] outbus,
  output logic        Q1,
  output logic        Q0,
  output logic        R,
  output logic        A7,
  output logic        count7,
  output logic        dz
);

  localparam logic [2:0] OP_DIV = 3'b110;

  logic [7:0] a_reg;
  logic [7:0] q_reg;
  logic [7:0] m_reg;
  logic       r_reg;
  logic [2:0] cnt;

  logic [7:0] a_nxt;
  logic [7:0] q_nxt;
  logic       r_nxt;
  logic       div_op;

  assign div_op = (op == OP_DIV);

  // Accumulator next value: one writer wins by priority, shifts only when no arithmetic write fires.
  always_comb begin
    a_nxt = a_reg;
    if (c[0]) begin
      a_nxt = 8'h00;
    end else if (c[10]) begin
      a_nxt = 8'h00;
    end else if (c[16]) begin
      case (op[1:0])
        2'b00:   a_nxt = q_reg & m_reg;
        2'b01:   a_nxt = q_reg | m_reg;
        2'b10:   a_nxt = q_reg ^ m_reg;
        default: a_nxt = q_reg & m_reg;
      endcase
    end else if (c[2]) begin
      // Q+~M+1 is the same as Q-M modulo 256.
      a_nxt = c[15] ? (q_reg - m_reg) : (q_reg + m_reg);
    end else if (c[3]) begin
      a_nxt = c[4] ? (a_reg - m_reg) : (a_reg + m_reg);
    end else if (c[13]) begin
      a_nxt = a_reg + m_reg;
    end else if (c[14]) begin
      a_nxt = a_reg - m_reg;
    end else if (c[7] && div_op && a_reg[7]) begin
      // Remainder restore after a negative trial subtraction.
      a_nxt = a_reg + m_reg;
    end else if (c[5]) begin
      a_nxt = {a_reg[7], a_reg[7:1]};
    end else if (c[12]) begin
      a_nxt = {a_reg[6:0], q_reg[7]};
    end
  end

  // Quotient/multiplier register and Booth bit: load, shifts, then quotient-bit overrides on Q[0].
  always_comb begin
    q_nxt = q_reg;
    r_nxt = r_reg;
    if (c[0]) begin
      q_nxt = inbus;
      r_nxt = 1'b0;
    end else begin
      if (c[5]) begin
        q_nxt = {a_reg[0], q_reg[7:1]};
        r_nxt = q_reg[0];
      end else if (c[12]) begin
        q_nxt = {q_reg[6:0], 1'b0};
      end
      if (c[7] && div_op) begin
        q_nxt[0] = ~a_reg[7];
      end else if (c[17]) begin
        q_nxt[0] = ~a_reg[7];
      end
    end
  end

  // Datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg <= 8'h00;
      q_reg <= 8'h00;
      m_reg <= 8'h00;
      r_reg <= 1'b0;
    end else begin
      a_reg <= a_nxt;
      q_reg <= q_nxt;
      r_reg <= r_nxt;
      if (c[1]) begin
        m_reg <= inbus;
      end
    end
  end

  // Step counter: cleared by a fresh operation, advanced by c6, wraps 7 to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 3'd0;
    end else if (c[0]) begin
      cnt <= 3'd0;
    end else if (c[6]) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Result register: each byte captured independently and held until rewritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outbus <= 16'h0000;
    end else begin
      if (c[8]) begin
        outbus[15:8] <= a_reg;
      end
      if (c[9]) begin
        outbus[7:0] <= q_reg;
      end
    end
  end

`ifdef ALU_DP_DZ_EN
  logic dz_reg;

  // Divide-by-zero flag: sampled from the current divisor on c11, cleared by a new operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_reg <= 1'b0;
    end else if (c[0]) begin
      dz_reg <= 1'b0;
    end else if (c[11]) begin
      dz_reg <= (m_reg == 8'h00);
    end
  end

  assign dz = dz_reg;
`else
  // Flag not built; c11 is ignored and folded away here.
  assign dz = c[11] & 1'b0;
`endif

  assign Q1     = q_reg[1];
  assign Q0     = q_reg[0];
  assign R      = r_reg;
  assign A7     = a_reg[7];
  assign count7 = (cnt == 3'd7);

endmodule
